// File: rtl/gmii_pkg.sv
// Shared GMII receive-path definitions: header byte offsets, the frame-guard
// input FSM states and the delay-line element carried alongside each byte.
package gmii_pkg;

    localparam int PREAMBLE_LEN = 8;
    localparam int SRC_MAC_OFS  = 14;
    localparam int HDR_LEN      = 20;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        ACCEPT,
        DISCARD,
        WAIT_IDLE
    } rx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       dv;
        logic       er;
        logic       abort;
    } dline_t;

    // Byte i of a MAC address in wire order (byte 0 sits in bits [47:40]).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
        logic [47:0] sh;
        sh = mac << (8 * i);
        return sh[47:40];
    endfunction

endpackage

// File: rtl/rx_decision_fifo.sv
// Two-entry, one-bit FIFO holding per-frame keep decisions between the
// header parser and the delayed output tap.
module rx_decision_fifo
    import gmii_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic din_i,
    input  logic pop_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);

    logic [1:0] mem_q;
    logic       wp_q;
    logic       rp_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wp_q] <= din_i;
                wp_q        <= ~wp_q;
            end
            if (pop_i) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign dout_o  = mem_q[rp_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

    // Inter-frame gap and pipeline depth bound occupancy to two; anything else is a design bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push_i && full_o));
            assert (!(pop_i && empty_o));
        end
    end

endmodule

// File: rtl/rx_frame_guard.sv
// GMII receive frame cleaner: drops runts, PHY-changeover casualties and (with
// RX_GUARD_ECHO_FILTER_EN defined) echoes of our own source MAC via a fixed delay line.
module rx_frame_guard
    import gmii_pkg::*;
#(
    parameter int DELAY = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] mac_address,
    input  logic        mac_valid,
    input  logic        trigger,
    input  logic [7:0]  up_data,
    input  logic        up_dv,
    input  logic        up_er,
    output logic [7:0]  down_data,
    output logic        down_dv,
    output logic        down_er,
    output logic [15:0] drop_count
);

    rx_state_e   state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic        abort_q, abort_d;
    logic        ghost_q;
    logic        dv_prev_q;
    logic [15:0] drop_q, drop_d;

    logic        frame_start;
    logic        push, push_keep;
    logic        abort_now, cnt_abort;
    logic        keep_hdr;

    // A burst already under way when reset releases owns no decision; mask it until dv drops.
    assign frame_start = up_dv & ~dv_prev_q & ~ghost_q;

`ifdef RX_GUARD_ECHO_FILTER_EN
    logic match_q, match_d;
    logic byte_ok;

    always_comb begin
        byte_ok = 1'b1;
        if (idx_q >= 5'(SRC_MAC_OFS)) begin
            byte_ok = (up_data == mac_byte(mac_address, 3'(idx_q - 5'(SRC_MAC_OFS))));
        end
    end

    assign match_d  = (state_q == HDR) ? (match_q & byte_ok) : 1'b1;
    assign keep_hdr = !(mac_valid && match_q && byte_ok);

    always_ff @(posedge clk) begin
        if (rst) match_q <= 1'b1;
        else     match_q <= match_d;
    end
`else
    logic unused_mac;
    assign unused_mac = ^{mac_address, mac_valid};
    assign keep_hdr   = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        abort_d   = abort_q;
        push      = 1'b0;
        push_keep = 1'b1;
        abort_now = 1'b0;
        cnt_abort = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start && trigger) begin
                    push      = 1'b1;
                    push_keep = 1'b0;
                    state_d   = WAIT_IDLE;
                end else if (frame_start) begin
                    state_d = HDR;
                    idx_d   = 5'd1;
                end else if (trigger || up_dv) begin
                    state_d = WAIT_IDLE;
                end
            end
            HDR: begin
                if (trigger) begin
                    push      = 1'b1;
                    push_keep = 1'b0;
                    state_d   = WAIT_IDLE;
                end else if (!up_dv) begin
                    push      = 1'b1;
                    push_keep = 1'b0;
                    state_d   = IDLE;
                end else if (idx_q == 5'(HDR_LEN - 1)) begin
                    push      = 1'b1;
                    push_keep = keep_hdr;
                    state_d   = keep_hdr ? ACCEPT : DISCARD;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            ACCEPT: begin
                if (trigger) begin
                    state_d   = WAIT_IDLE;
                    abort_d   = up_dv;
                    abort_now = up_dv;
                    cnt_abort = up_dv;
                end else if (!up_dv) begin
                    state_d = IDLE;
                end
            end
            DISCARD: begin
                if (trigger)     state_d = WAIT_IDLE;
                else if (!up_dv) state_d = IDLE;
            end
            WAIT_IDLE: begin
                abort_now = abort_q & up_dv;
                if (frame_start) begin
                    push      = 1'b1;
                    push_keep = 1'b0;
                end
                if (!up_dv) begin
                    abort_d = 1'b0;
                    if (!trigger) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        if (((push && !push_keep) || cnt_abort) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            abort_q   <= 1'b0;
            ghost_q   <= 1'b1;
            dv_prev_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            abort_q   <= abort_d;
            ghost_q   <= ghost_q & up_dv;
            dv_prev_q <= up_dv;
            drop_q    <= drop_d;
        end
    end

    dline_t dl_in;
    dline_t pipe_q [DELAY];

    always_comb begin
        dl_in       = '0;
        dl_in.data  = up_data;
        dl_in.dv    = up_dv & ~ghost_q;
        dl_in.er    = up_er;
        dl_in.abort = abort_now;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= dl_in;
            for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    dline_t tap;
    logic   odv_q, keep_q, keep_now, pop;
    logic   fifo_dout, fifo_full, fifo_empty;

    assign tap = pipe_q[DELAY-1];
    assign pop = tap.dv & ~odv_q;
    // Decision applies from the first delayed byte, so use the FIFO head directly on that cycle.
    assign keep_now = pop ? fifo_dout : keep_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            odv_q  <= 1'b0;
            keep_q <= 1'b0;
        end else begin
            odv_q  <= tap.dv;
            keep_q <= keep_now;
        end
    end

    rx_decision_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_keep),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic unused_flags;
    assign unused_flags = fifo_full ^ fifo_empty;

    assign down_dv    = tap.dv & keep_now;
    assign down_er    = down_dv & (tap.er | tap.abort);
    assign down_data  = down_dv ? tap.data : 8'h00;
    assign drop_count = drop_q;

endmodule
